// File: rtl/nibble_serial_sub_ctrl.sv
// Serial wide subtractor sequencer: computes a - b - bin one nibble per clock
// on an external 4-bit ripple-borrow subtractor, LSB nibble first.
module nibble_serial_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   bout,
  output logic                   ovf,
  output logic [3:0]             sub_a,
  output logic [3:0]             sub_b,
  output logic                   sub_bin,
  input  logic [3:0]             sub_d,
  input  logic                   sub_bout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic            borrow_q, borrow_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    sub_a    = 4'h0;
    sub_b    = 4'h0;
    sub_bin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!clear && start) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          idx_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      S_RUN: begin
        sub_a   = a_sh_q[3:0];
        sub_b   = b_sh_q[3:0];
        sub_bin = borrow_q;
        if (clear) begin
          // Abort keeps the partial diff/bout/ovf; the consumer ignores them.
          state_d = S_IDLE;
        end else begin
          diff_d[{idx_q, 2'b00} +: 4] = sub_d;
          borrow_d = sub_bout;
          a_sh_d   = a_sh_q >> 4;
          b_sh_d   = b_sh_q >> 4;
          if (idx_q == IW'(NIBBLES - 1)) begin
            state_d = S_DONE;
            idx_d   = '0;
            bout_d  = sub_bout;
            // Low nibble of the shifters now holds the operands' top nibble.
            ovf_d   = (a_sh_q[3] != b_sh_q[3]) && (sub_d[3] != a_sh_q[3]);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed bench for nibble_serial_sub_ctrl (NIBBLES=4) with a behavioural
// 4-bit ripple-borrow subtractor closing the datapath loop.
module tb_nibble_serial_sub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          clear;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          bin;
  logic          busy;
  logic          done;
  logic [W-1:0]  diff;
  logic          bout;
  logic          ovf;
  logic [3:0]    sub_a;
  logic [3:0]    sub_b;
  logic          sub_bin;
  logic [3:0]    sub_d;
  logic          sub_bout;
  logic [4:0]    sub_full;

  int n_checks;
  int n_fail;

  nibble_serial_sub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_bin  (sub_bin),
    .sub_d    (sub_d),
    .sub_bout (sub_bout)
  );

  // External datapath: 5-bit subtraction, bit 4 is the borrow-out.
  assign sub_full = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0000, sub_bin};
  assign sub_d    = sub_full[3:0];
  assign sub_bout = sub_full[4];

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, diff, bout, ovf, sub_a, sub_b, sub_bin} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b sub=%h/%h/%b, need all 0",
               busy, done, diff, bout, ovf, sub_a, sub_b, sub_bin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, need 0/0", busy, done);
    end
  endtask

  // Called at a negedge; starts one operation and checks the full result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] exp_diff, input logic exp_bout, input logic exp_ovf,
                        input string nm);
    int cyc;
    start = 1'b1;
    a = ta;
    b = tb_v;
    bin = tbin;
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    bin = ~tbin;
    n_checks++;
    if (busy !== 1'b1 || sub_a !== ta[3:0] || sub_b !== tb_v[3:0] || sub_bin !== tbin) begin
      n_fail++;
      $display("FAIL %s_first_nibble: got busy=%b sub=%h/%h/%b, need 1 %h/%h/%b",
               nm, busy, sub_a, sub_b, sub_bin, ta[3:0], tb_v[3:0], tbin);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != NIBBLES) begin
      n_fail++;
      $display("FAIL %s_latency: got done after %0d cycles, need %0d", nm, cyc, NIBBLES);
    end
    n_checks++;
    if (diff !== exp_diff || bout !== exp_bout || ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s_result: got diff=%h bout=%b ovf=%b, need diff=%h bout=%b ovf=%b",
               nm, diff, bout, ovf, exp_diff, exp_bout, exp_ovf);
    end
    n_checks++;
    if (busy !== 1'b1 || sub_a !== 4'h0 || sub_b !== 4'h0 || sub_bin !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_state: got busy=%b sub=%h/%h/%b, need 1 0/0/0",
               nm, busy, sub_a, sub_b, sub_bin);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_diff) begin
      n_fail++;
      $display("FAIL %s_after_done: got done=%b busy=%b diff=%h, need 0 0 %h",
               nm, done, busy, diff, exp_diff);
    end
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "wrap");
  endtask

  task automatic test_overflow();
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovf");
    run_op(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, "bin");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "ovf_neg");
  endtask

  task automatic test_ignore_start();
    int cyc;
    int n_done;
    start = 1'b1;
    a = 16'h4321;
    b = 16'h1111;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    cyc = 0;
    while (cyc < 12) begin
      // Stray starts with other operands during RUN and during DONE.
      if (cyc == 1 || done === 1'b1) begin
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'h0001;
        bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) n_done++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d done pulses, need 1", n_done);
    end
    n_checks++;
    if (diff !== 16'h3210 || bout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got diff=%h bout=%b ovf=%b busy=%b, need 3210 0 0 0",
               diff, bout, ovf, busy);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    a = 16'h9999;
    b = 16'h1234;
    bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, bout, ovf, sub_a, sub_b, sub_bin} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b sub=%h/%h/%b, need all 0",
               busy, done, diff, bout, ovf, sub_a, sub_b, sub_bin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_clear();
    int n_done;
    start = 1'b1;
    a = 16'h5555;
    b = 16'h1111;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sub_a !== 4'h0 || sub_b !== 4'h0 || sub_bin !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: got busy=%b done=%b sub=%h/%h/%b, need 0 0 0/0/0",
               busy, done, sub_a, sub_b, sub_bin);
    end
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL clear_no_done: got %0d busy/done cycles after clear, need 0", n_done);
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'hF00F, 16'h0FF0, 1'b0, 16'hE01F, 1'b0, 1'b0, "b2b_first");
    run_op(16'h0100, 16'h0200, 1'b1, 16'hFEFF, 1'b1, 1'b0, "b2b_second");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_ignore_start();
    test_async_reset();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
